jpu_wb_timer: RTL and testbench

//  Wishbone B3 classic responder (slave) for the CPU's data-bus initiator: a programmable down-counting

---
 rtl/jpu_wb_timer_pkg.sv | 39 +++
 rtl/jpu_tick_gen.sv | 33 +++
 rtl/jpu_wb_timer.sv | 161 ++++++++++++++++
 tb/tb_jpu_wb_timer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/jpu_wb_timer_pkg.sv
// Shared definitions for the Wishbone interval timer: register offsets,
// CTRL layout, reset defaults and a byte-lane merge helper.
package jpu_wb_timer_pkg;

  // Register select values (byte address bits [3:2])
  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_STATUS = 2'd1;
  localparam logic [1:0] TMR_PERIOD = 2'd2;
  localparam logic [1:0] TMR_COUNT  = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_RELOAD_BIT = 2;

  // 100 ticks of 100 us gives the 10 ms OS tick
  localparam logic [31:0] TMR_PERIOD_DEFAULT = 32'd100;

  typedef struct packed {
    logic reload;
    logic irq_en;
    logic en;
  } timer_ctrl_s;

  // Replace only the bytes whose lane enable is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] m;
    m = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        m[8*b +: 8] = new_v[8*b +: 8];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/jpu_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and pulses o_tick in the
// cycle the count wraps. Held at zero while disabled or cleared.
module jpu_tick_gen #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = i_en & ~i_clr & w_wrap;

  // Prescale counter: restart on disable, clear request or wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jpu_wb_timer.sv
// Wishbone B3 classic responder: down-counting interval timer with a
// maskable level interrupt. Optional JPU_TIMER_WB_ERR_EN answers misaligned
// accesses with wb_err_o instead of wb_ack_o.
module jpu_wb_timer
  import jpu_wb_timer_pkg::*;
#(
  parameter int          PRESCALE   = 1000,
  parameter logic [31:0] PERIOD_RST = TMR_PERIOD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        irq_o
);

  timer_ctrl_s r_ctrl;
  logic        r_expired;
  logic [31:0] r_period;
  logic [31:0] r_count;
  logic [31:0] r_dat;
  logic        r_ack;
  logic        r_err;
  logic        r_irq;

  logic        w_acc;
  logic        w_bad;
  logic        w_ack_nxt;
  logic        w_err_nxt;
  logic        w_wr;
  logic [1:0]  w_reg;
  logic        w_wr_ctrl;
  logic        w_wr_stat;
  logic        w_wr_per;
  logic        w_wr_cnt;
  logic        w_en_off;
  logic        w_en_rise;
  logic        w_tick;
  logic        w_tick_eff;
  logic        w_expire;
  logic [31:0] w_rdata;

  // A new access is only accepted while no response is outstanding, which
  // gives exactly one response cycle per strobe.
  assign w_acc = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_reg = wb_adr_i[3:2];

`ifdef JPU_TIMER_WB_ERR_EN
  assign w_bad = (wb_adr_i[1:0] != 2'b00);
`else
  logic w_unused_adr;
  assign w_unused_adr = ^wb_adr_i[1:0];
  assign w_bad        = 1'b0;
`endif

  assign w_ack_nxt = w_acc & ~w_bad;
  assign w_err_nxt = w_acc & w_bad;
  assign w_wr      = w_ack_nxt & wb_we_i;

  assign w_wr_ctrl = w_wr & (w_reg == TMR_CTRL)   & wb_sel_i[0];
  assign w_wr_stat = w_wr & (w_reg == TMR_STATUS) & wb_sel_i[0];
  assign w_wr_per  = w_wr & (w_reg == TMR_PERIOD) & (|wb_sel_i);
  assign w_wr_cnt  = w_wr & (w_reg == TMR_COUNT)  & (|wb_sel_i);

  // A CTRL write that turns the timer off swallows a coinciding tick; a
  // COUNT write overrides both the decrement and any expiry from that tick.
  assign w_en_off   = w_wr_ctrl & ~wb_dat_i[CTRL_EN_BIT];
  assign w_en_rise  = w_wr_ctrl & wb_dat_i[CTRL_EN_BIT] & ~r_ctrl.en;
  assign w_tick_eff = w_tick & ~w_en_off;
  assign w_expire   = w_tick_eff & ~w_wr_cnt & (r_count <= 32'd1);

  jpu_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_ctrl.en),
    .i_clr (w_en_rise),
    .o_tick(w_tick)
  );

  // Read-data mux of the live register values
  always_comb begin
    w_rdata = 32'd0;
    case (w_reg)
      TMR_CTRL:   w_rdata = {29'd0, r_ctrl};
      TMR_STATUS: w_rdata = {31'd0, r_expired};
      TMR_PERIOD: w_rdata = r_period;
      TMR_COUNT:  w_rdata = r_count;
      default:    w_rdata = 32'd0;
    endcase
  end

  // Bus response registers: ack/err one cycle after strobe, read data with ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_ack_nxt;
      r_err <= w_err_nxt;
      r_dat <= (w_ack_nxt & ~wb_we_i) ? w_rdata : 32'd0;
    end
  end

  // Timer state: CTRL, STATUS, PERIOD, COUNT and the registered interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_expired <= 1'b0;
      r_period  <= PERIOD_RST;
      r_count   <= 32'd0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= '{reload: wb_dat_i[CTRL_RELOAD_BIT],
                    irq_en: wb_dat_i[CTRL_IRQ_EN_BIT],
                    en:     wb_dat_i[CTRL_EN_BIT]};
      end else if (w_expire && !r_ctrl.reload) begin
        r_ctrl.en <= 1'b0;
      end

      // New expiry wins over a simultaneous write-one-to-clear
      if (w_expire) begin
        r_expired <= 1'b1;
      end else if (w_wr_stat && wb_dat_i[0]) begin
        r_expired <= 1'b0;
      end

      if (w_wr_per) begin
        r_period <= merge_bytes(r_period, wb_dat_i, wb_sel_i);
      end

      if (w_wr_cnt) begin
        r_count <= merge_bytes(r_count, wb_dat_i, wb_sel_i);
      end else if (w_tick_eff) begin
        if (r_count <= 32'd1) begin
          r_count <= r_ctrl.reload ? r_period : 32'd0;
        end else begin
          r_count <= r_count - 32'd1;
        end
      end

      r_irq <= r_expired & r_ctrl.irq_en;
    end
  end

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_jpu_wb_timer.sv
// Directed self-checking bench for jpu_wb_timer (PRESCALE=4, PERIOD_RST=100).
module tb_jpu_wb_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  adr = 4'h0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat = 32'h0;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  jpu_wb_timer #(
    .PRESCALE(4),
    .PERIOD_RST(32'd100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_we_i (we),
    .wb_adr_i(adr),
    .wb_sel_i(sel),
    .wb_dat_i(dat),
    .wb_dat_o(dat_o),
    .wb_ack_o(ack),
    .wb_err_o(err),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One classic-cycle access; returns data/ack/err sampled after the response edge
  task automatic bus(input logic w, input logic [3:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic a_o, output logic e_o, output int c);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    @(posedge clk); #1;
    rd = dat_o; a_o = ack; e_o = err; c = cyc_cnt;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  int last_c;

  task automatic wr(input string tag, input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd;
    logic a_o, e_o;
    int c;
    bus(1'b1, a, s, d, rd, a_o, e_o, c);
    last_c = c;
    chk(tag, {31'd0, a_o}, 32'd1);
  endtask

  task automatic rdc(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic a_o, e_o;
    int c;
    bus(1'b0, a, 4'hF, 32'h0, rd, a_o, e_o, c);
    last_c = c;
    chk(tag, rd, exp);
  endtask

  // Advance to just after edge number 'target', bounded
  task automatic wait_to(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (cyc_cnt >= target) break;
      @(posedge clk); #1;
    end
    if (cyc_cnt < target) chk("wait_to", cyc_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [31:0] rd;
    logic a_o, e_o;
    int c;

    // Reset values of the bus outputs
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {dat_o[29:0], ack, err, irq}, 33'h0 >> 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset register values and single-cycle ack
    rdc("rst_ctrl", 4'h0, 32'd0);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, ack}, 32'd0);
    rdc("rst_status", 4'h4, 32'd0);
    rdc("rst_period", 4'h8, 32'd100);
    rdc("rst_count", 4'hC, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Periodic reload: PERIOD=3, 4 clocks per tick -> expiry every 12 clocks
    wr("wr_ack", 4'h8, 4'hF, 32'd3);
    wr("wr_ack", 4'hC, 4'hF, 32'd3);
    wr("wr_ack", 4'h0, 4'hF, 32'h7);
    c0 = last_c;
    wait_to(c0 + 12);
    chk("irq_before_exp1", {31'd0, irq}, 32'd0);
    wait_to(c0 + 13);
    chk("irq_exp1", {31'd0, irq}, 32'd1);
    wr("wr_ack", 4'h4, 4'h1, 32'd1);
    wait_to(c0 + 15);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    wait_to(c0 + 24);
    chk("irq_before_exp2", {31'd0, irq}, 32'd0);
    wait_to(c0 + 25);
    chk("irq_exp2", {31'd0, irq}, 32'd1);
    rdc("count_reloaded", 4'hC, 32'd3);
    wr("wr_ack", 4'h0, 4'h1, 32'h0);
    wr("wr_ack", 4'h4, 4'h1, 32'h1);

    // One-shot: reload=0, PERIOD=2 -> single expiry, en self-clears
    wr("wr_ack", 4'h8, 4'hF, 32'd2);
    wr("wr_ack", 4'hC, 4'hF, 32'd2);
    wr("wr_ack", 4'h0, 4'h1, 32'h3);
    c0 = last_c;
    wait_to(c0 + 12);
    rdc("oneshot_ctrl", 4'h0, 32'h2);
    rdc("oneshot_status", 4'h4, 32'd1);
    rdc("oneshot_count", 4'hC, 32'd0);
    chk("oneshot_irq", {31'd0, irq}, 32'd1);
    wr("wr_ack", 4'h4, 4'h1, 32'h1);
    wait_to(last_c + 20);
    rdc("oneshot_no_more", 4'h4, 32'd0);

    // W1C in the same cycle as a new expiry: expired stays set
    wr("wr_ack", 4'h8, 4'hF, 32'd3);
    wr("wr_ack", 4'hC, 4'hF, 32'd1);
    wr("wr_ack", 4'h0, 4'h1, 32'h7);
    c0 = last_c;
    wait_to(c0 + 3);
    wr("wr_ack", 4'h4, 4'h1, 32'h1);
    chk("w1c_on_tick_edge", last_c, c0 + 4);
    rdc("expired_kept", 4'h4, 32'd1);
    wr("wr_ack", 4'h4, 4'h1, 32'h1);
    chk("irq_still_high", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    chk("irq_drops", {31'd0, irq}, 32'd0);
    wr("wr_ack", 4'h0, 4'h1, 32'h0);
    wr("wr_ack", 4'h4, 4'h1, 32'h1);

    // Byte-lane write to COUNT
    wr("wr_ack", 4'hC, 4'hF, 32'h11223344);
    wr("wr_ack", 4'hC, 4'b0010, 32'h0000AB00);
    rdc("count_bytelane", 4'hC, 32'h1122AB44);

    // COUNT write on a tick edge wins over the decrement
    wr("wr_ack", 4'hC, 4'hF, 32'h100);
    wr("wr_ack", 4'h0, 4'h1, 32'h1);
    c0 = last_c;
    wait_to(c0 + 5);
    rdc("count_decrement", 4'hC, 32'hFF);
    wait_to(c0 + 7);
    wr("wr_ack", 4'hC, 4'hF, 32'h55);
    chk("cnt_wr_on_tick_edge", last_c, c0 + 8);
    rdc("count_bus_wins", 4'hC, 32'h55);

    // Disabling on a tick edge suppresses that tick
    wait_to(c0 + 11);
    wr("wr_ack", 4'h0, 4'h1, 32'h0);
    chk("ctrl_off_on_tick_edge", last_c, c0 + 12);
    wait_to(last_c + 10);
    rdc("count_held_off", 4'hC, 32'h55);
    rdc("ctrl_off", 4'h0, 32'h0);

    // Strobe without cycle: no ack, no side effect
    @(negedge clk);
    cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 4'h8; sel = 4'hF; dat = 32'hDEAD;
    @(posedge clk); #1;
    chk("no_cyc_no_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    rdc("no_cyc_period", 4'h8, 32'd3);

`ifdef JPU_TIMER_WB_ERR_EN
    bus(1'b1, 4'h2, 4'hF, 32'hFFFFFFFF, rd, a_o, e_o, c);
    chk("misaligned_err", {30'd0, a_o, e_o}, 32'h1);
    @(posedge clk); #1;
    chk("err_one_cycle", {31'd0, err}, 32'd0);
    rdc("misaligned_no_effect", 4'h0, 32'h0);
`else
    bus(1'b0, 4'hA, 4'hF, 32'h0, rd, a_o, e_o, c);
    chk("misaligned_ack", {30'd0, a_o, e_o}, 32'h2);
    chk("misaligned_data", rd, 32'd3);
`endif

    // Reset in the middle of an access
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h8; sel = 4'hF; dat = 32'h77;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_no_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    rdc("rst_mid_period", 4'h8, 32'd100);
    rdc("rst_mid_count", 4'hC, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
